// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Operand forwarding selects and ID-stage stall for an N-slot forwarding
//   network, plus a per-register scoreboard that tracks writes still owed by
//   variable-latency units (multi-cycle memory, divider).
//
//   Interface contract, stated once: the ID stage presents an instruction with
//   id_valid. It advances, and a long-latency op issues, on every rising edge
//   where id_valid=1 and stall=0. The long-latency unit reports a result with
//   a single-cycle done_valid pulse carrying done_rd. That completion is never
//   back-pressured. In the same cycle it clears the hazard, so the consumer can
//   take the value from the completion bus (fwd = NSRC+1).
module hazard_scoreboard #(
    parameter int AW        = 5,
    parameter int NSRC      = 3,
    parameter int NOFWD_REG = 30,
    parameter int MAX_OUT   = 4,
    localparam int CW       = $clog2(MAX_OUT + 1),
    localparam int FW       = $clog2(NSRC + 2),
    localparam int NREG     = 2 ** AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [AW-1:0]      id_rs,
    input  logic [AW-1:0]      id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic               id_long,
    input  logic [AW-1:0]      id_rd,
    input  logic [NSRC*AW-1:0] stg_rd,
    input  logic [NSRC-1:0]    stg_wr,
    input  logic [NSRC-1:0]    stg_kill,
    input  logic [NSRC-1:0]    stg_rdy,
    input  logic               done_valid,
    input  logic [AW-1:0]      done_rd,
    output logic [FW-1:0]      fwd_a,
    output logic [FW-1:0]      fwd_b,
    output logic               stall,
    output logic [NREG-1:0]    pending,
    output logic [CW-1:0]      outstanding,
    output logic [31:0]        stall_cnt,
    output logic               err_spurious
);

    localparam logic [AW-1:0] NOFWD    = AW'(NOFWD_REG);
    localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUT);

    logic [NREG-1:0] pending_q, pending_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic            err_q, err_d;

    logic            dstall_a, dstall_b;
    logic            pstall_a, pstall_b;
    logic            waw_stall, full_stall;
    logic            issue, complete;

    // Registers 0 and NOFWD never carry a dependency worth tracking.
    function automatic logic trackable(input logic [AW-1:0] x);
        return (x != '0) && (x != NOFWD);
    endfunction

    // Returns {data_stall, select} for one source operand. The nearest live
    // producer shadows every farther slot, even a ready one, because only it
    // holds the youngest value.
    function automatic logic [FW:0] src_fwd(
        input logic [AW-1:0]      x,
        input logic               use_x,
        input logic [NSRC*AW-1:0] rd,
        input logic [NSRC-1:0]    wr,
        input logic [NSRC-1:0]    kill,
        input logic [NSRC-1:0]    rdy,
        input logic               dv,
        input logic [AW-1:0]      drd
    );
        logic          found;
        logic          dstall;
        logic [FW-1:0] sel;
        found  = 1'b0;
        dstall = 1'b0;
        sel    = '0;
        if (use_x && trackable(x)) begin
            for (int k = 0; k < NSRC; k++) begin
                if (!found && wr[k] && !kill[k] && (rd[k*AW +: AW] == x)) begin
                    found = 1'b1;
                    if (rdy[k]) sel = FW'(k + 1);
                    else        dstall = 1'b1;
                end
            end
            if (!found && dv && (drd == x)) sel = FW'(NSRC + 1);
        end
        return {dstall, sel};
    endfunction

    // Forwarding selects and the individual stall causes.
    always_comb begin
        {dstall_a, fwd_a} = src_fwd(id_rs, id_use_rs, stg_rd, stg_wr, stg_kill,
                                    stg_rdy, done_valid, done_rd);
        {dstall_b, fwd_b} = src_fwd(id_rt, id_use_rt, stg_rd, stg_wr, stg_kill,
                                    stg_rdy, done_valid, done_rd);
        // A completion landing this cycle already resolves the dependency.
        pstall_a   = id_use_rs && trackable(id_rs) && pending_q[id_rs] &&
                     !(done_valid && (done_rd == id_rs));
        pstall_b   = id_use_rt && trackable(id_rt) && pending_q[id_rt] &&
                     !(done_valid && (done_rd == id_rt));
        waw_stall  = id_long && pending_q[id_rd] &&
                     !(done_valid && (done_rd == id_rd));
        full_stall = id_long && (outstanding_q == CNT_FULL) && !done_valid;
        stall      = id_valid && (dstall_a || dstall_b || pstall_a || pstall_b ||
                                  waw_stall || full_stall);
    end

    // Next-state for scoreboard, occupancy count, stall counter and error flag.
    always_comb begin
        issue         = id_valid && id_long && !stall && (id_rd != '0);
        complete      = done_valid && pending_q[done_rd];
        pending_d     = pending_q;
        outstanding_d = outstanding_q;
        stall_cnt_d   = stall_cnt_q;
        err_d         = err_q;

        // Clear before set so a same-register issue keeps the bit.
        if (complete) pending_d[done_rd] = 1'b0;
        if (issue)    pending_d[id_rd]   = 1'b1;
        pending_d[0] = 1'b0;

        if (issue && !complete) begin
            if (outstanding_q != CNT_FULL) outstanding_d = outstanding_q + 1'b1;
        end else if (!issue && complete) begin
            if (outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
        end

        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;

        if (done_valid && !pending_q[done_rd]) err_d = 1'b1;
    end

    // State registers; reset forgets every in-flight long-latency write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            stall_cnt_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            stall_cnt_q   <= stall_cnt_d;
            err_q         <= err_d;
        end
    end

    assign pending      = pending_q;
    assign outstanding  = outstanding_q;
    assign stall_cnt    = stall_cnt_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios followed by random traffic,
// all checked against a register-array model of the hazard rules.
module tb_hazard_scoreboard;

    localparam int AW        = 5;
    localparam int NSRC      = 3;
    localparam int NOFWD_REG = 30;
    localparam int MAX_OUT   = 4;
    localparam int CW        = $clog2(MAX_OUT + 1);
    localparam int FW        = $clog2(NSRC + 2);
    localparam int NREG      = 2 ** AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic               id_valid, id_use_rs, id_use_rt, id_long, done_valid;
    logic [AW-1:0]      id_rs, id_rt, id_rd, done_rd;
    logic [NSRC*AW-1:0] stg_rd;
    logic [NSRC-1:0]    stg_wr, stg_kill, stg_rdy;
    logic [FW-1:0]      fwd_a, fwd_b;
    logic               stall, err_spurious;
    logic [NREG-1:0]    pending;
    logic [CW-1:0]      outstanding;
    logic [31:0]        stall_cnt;

    hazard_scoreboard #(.AW(AW), .NSRC(NSRC), .NOFWD_REG(NOFWD_REG), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_long(id_long), .id_rd(id_rd),
        .stg_rd(stg_rd), .stg_wr(stg_wr), .stg_kill(stg_kill), .stg_rdy(stg_rdy),
        .done_valid(done_valid), .done_rd(done_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
        .pending(pending), .outstanding(outstanding),
        .stall_cnt(stall_cnt), .err_spurious(err_spurious)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [NREG-1:0] exp_q[$];

    bit          pend_m[NREG];
    logic [31:0] scnt_m;
    bit          err_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int popcount_m();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += pend_m[i];
        return c;
    endfunction

    function automatic logic [NREG-1:0] pend_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = pend_m[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) pend_m[i] = 0;
        scnt_m = '0;
        err_m  = 0;
        exp_q.delete();
    endtask

    // Hazard rules for one source operand, evaluated on the current inputs.
    function automatic void model_src(input int x, input bit use_x,
                                      output int fwd, output bit dst, output bit pst);
        bit same_done;
        fwd = 0; dst = 0; pst = 0;
        if (!use_x || x == 0 || x == NOFWD_REG) return;
        same_done = done_valid && (int'(done_rd) == x);
        pst = pend_m[x] && !same_done;
        for (int k = 0; k < NSRC; k++) begin
            if (stg_wr[k] && !stg_kill[k] && int'(stg_rd[k*AW +: AW]) == x) begin
                if (stg_rdy[k]) fwd = k + 1;
                else            dst = 1;
                return;
            end
        end
        if (same_done) fwd = NSRC + 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_long = 0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        stg_rd = '0; stg_wr = '0; stg_kill = '0; stg_rdy = '0;
        done_valid = 0; done_rd = '0;
    endtask

    task automatic set_slot(input int k, input int rd, input bit wr, input bit kill, input bit rdy);
        stg_rd[k*AW +: AW] = AW'(rd);
        stg_wr[k]   = wr;
        stg_kill[k] = kill;
        stg_rdy[k]  = rdy;
    endtask

    // Directed expectation on the combinational outputs for the current inputs.
    task automatic expect_comb(input string tag, input int fa, input int fb, input bit st);
        #1;
        check({tag, ":fwd_a"}, fwd_a, fa);
        check({tag, ":fwd_b"}, fwd_b, fb);
        check({tag, ":stall"}, stall, st);
    endtask

    // One clock: check combinational outputs against the model, advance the
    // model across the edge, then check the registered outputs.
    task automatic step(input string tag);
        int fa, fb;
        bit da, db, pa, pb, waw, full, es, issue;
        #1;
        model_src(id_rs, id_use_rs, fa, da, pa);
        model_src(id_rt, id_use_rt, fb, db, pb);
        waw  = id_long && pend_m[id_rd] && !(done_valid && done_rd == id_rd);
        full = id_long && popcount_m() == MAX_OUT && !done_valid;
        es   = id_valid && (da || db || pa || pb || waw || full);
        check({tag, ":fwd_a"}, fwd_a, fa);
        check({tag, ":fwd_b"}, fwd_b, fb);
        check({tag, ":stall"}, stall, es);

        issue = id_valid && id_long && !es && id_rd != 0;
        if (done_valid) begin
            if (pend_m[done_rd]) pend_m[done_rd] = 0;
            else                 err_m = 1;
        end
        if (issue) pend_m[id_rd] = 1;
        if (es && scnt_m != 32'hFFFF_FFFF) scnt_m = scnt_m + 1;
        exp_q.push_back(pend_vec());

        @(posedge clk);
        #1;
        check({tag, ":pending"}, pending, exp_q.pop_front());
        check({tag, ":outstanding"}, outstanding, popcount_m());
        check({tag, ":stall_cnt"}, stall_cnt, scnt_m);
        check({tag, ":err"}, err_spurious, err_m);
        @(negedge clk);
    endtask

    task automatic issue_long(input int rd);
        drive_idle();
        id_valid = 1; id_long = 1; id_rd = AW'(rd);
        step("issue");
    endtask

    task automatic complete(input int rd);
        drive_idle();
        done_valid = 1; done_rd = AW'(rd);
        step("done");
    endtask

    function automatic int rand_reg();
        if ($urandom_range(0, 9) == 0) return NOFWD_REG;
        return $urandom_range(0, 12);
    endfunction

    task automatic rand_cycle();
        int pq[$];
        drive_idle();
        id_valid  = ($urandom_range(0, 9) != 0);
        id_rs     = AW'(rand_reg());
        id_rt     = AW'(rand_reg());
        id_use_rs = $urandom_range(0, 3) != 0;
        id_use_rt = $urandom_range(0, 1);
        id_long   = $urandom_range(0, 9) < 3;
        id_rd     = AW'(rand_reg());
        for (int k = 0; k < NSRC; k++)
            set_slot(k, rand_reg(), $urandom_range(0, 9) < 6,
                     $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 7);
        for (int i = 0; i < NREG; i++) if (pend_m[i]) pq.push_back(i);
        if (pq.size() > 0 && $urandom_range(0, 9) < 4) begin
            done_valid = 1;
            done_rd    = AW'(pq[$urandom_range(0, pq.size() - 1)]);
        end else if (popcount_m() < MAX_OUT && $urandom_range(0, 19) == 0) begin
            done_valid = 1;
            done_rd    = AW'(rand_reg());
        end
        step("rand");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 0;
        drive_idle();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check("rst:pending", pending, 0);
        check("rst:outstanding", outstanding, 0);
        check("rst:stall_cnt", stall_cnt, 0);
        check("rst:err", err_spurious, 0);
        id_valid = 1; id_use_rs = 1; id_rs = 5;
        set_slot(0, 5, 1, 0, 1);
        expect_comb("rst_comb", 1, 0, 0);
        drive_idle();
        rst_n = 1;
        @(negedge clk);

        // Nearest slot wins; killing it exposes the next one.
        id_valid = 1; id_use_rs = 1; id_rs = 5;
        set_slot(0, 5, 1, 0, 1);
        set_slot(1, 5, 1, 0, 1);
        expect_comb("t1_near", 1, 0, 0);
        step("t1a");
        stg_kill[0] = 1;
        expect_comb("t1_kill", 2, 0, 0);
        step("t1b");

        // Load-use: a not-ready winner stalls and shadows farther slots.
        drive_idle();
        id_valid = 1; id_use_rt = 1; id_rt = 7;
        set_slot(0, 7, 1, 0, 0);
        set_slot(2, 7, 1, 0, 1);
        expect_comb("t2_lu", 0, 0, 1);
        step("t2a");
        stg_rdy[0] = 1;
        expect_comb("t2_rdy", 0, 1, 0);
        step("t2b");

        // Long-latency dependency released by a same-cycle completion.
        issue_long(9);
        check("t3_pend9", pending[9], 1);
        drive_idle();
        id_valid = 1; id_use_rs = 1; id_rs = 9;
        expect_comb("t3_wait", 0, 0, 1);
        step("t3a");
        step("t3b");
        done_valid = 1; done_rd = 9;
        expect_comb("t3_done", NSRC + 1, 0, 0);
        step("t3c");
        check("t3_clear9", pending[9], 0);

        // Structural full, then a same-cycle completion lets the issue through.
        for (int r = 1; r <= MAX_OUT; r++) issue_long(r);
        check("t4_full", outstanding, MAX_OUT);
        drive_idle();
        id_valid = 1; id_long = 1; id_rd = 5;
        expect_comb("t4_stall", 0, 0, 1);
        step("t4a");
        done_valid = 1; done_rd = 1;
        expect_comb("t4_swap", 0, 0, 0);
        step("t4b");
        check("t4_cnt", outstanding, MAX_OUT);
        for (int r = 2; r <= 5; r++) complete(r);
        check("t4_drain", outstanding, 0);

        // Registers 0 and NOFWD_REG are invisible to forwarding and stalls.
        drive_idle();
        id_valid = 1; id_use_rs = 1; id_use_rt = 1; id_rs = 0; id_rt = AW'(NOFWD_REG);
        for (int k = 0; k < NSRC; k++) set_slot(k, (k % 2 == 0) ? 0 : NOFWD_REG, 1, 0, k != 1);
        expect_comb("t5_zero", 0, 0, 0);
        step("t5a");
        check("t5_err0", err_spurious, 0);
        id_rs = AW'(NOFWD_REG); id_rt = 0;
        for (int k = 0; k < NSRC; k++) set_slot(k, (k % 2 == 0) ? NOFWD_REG : 0, 1, 0, 0);
        done_valid = 1; done_rd = 0;
        expect_comb("t5_done0", 0, 0, 0);
        step("t5b");
        complete(12);
        check("t5_err", err_spurious, 1);
        check("t5_cnt", outstanding, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) rand_cycle();

        // Asynchronous reset in the middle of a stall with ops in flight.
        for (int i = 0; i < NREG; i++) if (pend_m[i]) complete(i);
        for (int r = 1; r <= 3; r++) issue_long(r);
        drive_idle();
        id_valid = 1; id_use_rs = 1; id_rs = 1;
        step("t6_stall");
        #2;
        rst_n = 0;
        #1;
        model_clear();
        check("t6_pending", pending, 0);
        check("t6_outstanding", outstanding, 0);
        check("t6_stall_cnt", stall_cnt, 0);
        check("t6_err", err_spurious, 0);
        @(negedge clk);
        rst_n = 1;
        drive_idle();
        id_valid = 1; id_use_rt = 1; id_rt = 7;
        set_slot(0, 7, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("t6_count");
            check("t6_cnt_val", stall_cnt, i + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
